// File: rtl/trace_pkg.sv
// Shared types for the writeback trace buffer: capture FSM states and the
// stored trace entry (fields sized to the widest supported configuration).
package trace_pkg;

  localparam int TR_ADDR_MAX = 16;
  localparam int TR_DATA_MAX = 64;
  localparam int TR_CYC_MAX  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [TR_ADDR_MAX-1:0] waddr;
    logic [TR_DATA_MAX-1:0] wdata;
    logic [TR_CYC_MAX-1:0]  cycle;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular trace storage with push/pop, optional overwrite-oldest when full,
// and a registered head entry (a push into an empty buffer shows next cycle).
module trace_fifo
  import trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter bit  WRAP  = 1'b0,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  trace_entry_t     push_entry,
  input  logic             rd_ready,
  output logic             rd_valid,
  output trace_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full_hit
);

  trace_entry_t     mem_r [DEPTH];
  trace_entry_t     head_r, head_next_s;
  logic [PTR_W-1:0] head_ptr_r, head_ptr_next_s;
  logic [PTR_W-1:0] tail_ptr_r, tail_ptr_next_s;
  logic [CNT_W-1:0] count_r, count_next_s;
  logic             rd_valid_r;
  logic             pop_s, full_hit_s, wr_s, adv_s;

  // Next pointer/count/head computation; the head is bypassed from the push
  // when the entry being written lands exactly at the next head slot.
  always_comb begin
    pop_s      = rd_valid_r && rd_ready;
    full_hit_s = push && (count_r == CNT_W'(DEPTH)) && !pop_s;
    wr_s       = push && !(full_hit_s && !WRAP);
    adv_s      = pop_s || (full_hit_s && WRAP);
    head_ptr_next_s = head_ptr_r;
    tail_ptr_next_s = tail_ptr_r;
    count_next_s    = count_r;
    head_next_s     = {$bits(trace_entry_t){1'b0}};
    if (clr) begin
      head_ptr_next_s = {PTR_W{1'b0}};
      tail_ptr_next_s = {PTR_W{1'b0}};
      count_next_s    = {CNT_W{1'b0}};
    end else begin
      head_ptr_next_s = adv_s ? head_ptr_r + PTR_W'(1) : head_ptr_r;
      tail_ptr_next_s = wr_s  ? tail_ptr_r + PTR_W'(1) : tail_ptr_r;
      if (wr_s && !adv_s) begin
        count_next_s = count_r + CNT_W'(1);
      end else if (adv_s && !wr_s) begin
        count_next_s = count_r - CNT_W'(1);
      end else begin
        count_next_s = count_r;
      end
      if (count_next_s == {CNT_W{1'b0}}) begin
        head_next_s = {$bits(trace_entry_t){1'b0}};
      end else if (wr_s && (tail_ptr_r == head_ptr_next_s)) begin
        head_next_s = push_entry;
      end else begin
        head_next_s = mem_r[head_ptr_next_s];
      end
    end
  end

  // Pointer, occupancy and registered head-entry state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr_r <= {PTR_W{1'b0}};
      tail_ptr_r <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      rd_valid_r <= 1'b0;
      head_r     <= {$bits(trace_entry_t){1'b0}};
    end else begin
      head_ptr_r <= head_ptr_next_s;
      tail_ptr_r <= tail_ptr_next_s;
      count_r    <= count_next_s;
      rd_valid_r <= (count_next_s != {CNT_W{1'b0}});
      head_r     <= head_next_s;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_s && !clr && !rst) begin
      mem_r[tail_ptr_r] <= push_entry;
    end
  end

  assign rd_valid = rd_valid_r;
  assign head     = head_r;
  assign count    = count_r;
  assign full_hit = full_hit_s;

endmodule

// File: rtl/wb_trace_buffer.sv
// Register-file writeback trace buffer: arm, trigger on a write to trig_addr,
// capture writes with cycle stamps, and count taken branches and jumps.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  ADDR_W    = 5,
  parameter int  DEPTH     = 16,
  parameter int  CYC_W     = 16,
  parameter int  WRAP_MODE = 0,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              br_taken,
  input  logic              jump,
  input  logic              arm,
  input  logic              clear,
  input  logic [ADDR_W-1:0] trig_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_waddr,
  output logic [DATA_W-1:0] rd_wdata,
  output logic [CYC_W-1:0]  rd_cycle,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [1:0]        state,
  output logic [CYC_W-1:0]  cycle_cnt,
  output logic [CYC_W-1:0]  br_cnt,
  output logic [CYC_W-1:0]  jump_cnt
);

  trace_state_t     state_r, state_next_s;
  trace_entry_t     entry_s, head_s;
  logic             we_s, trig_s, push_s, full_hit_s;
  logic             overflow_r, head_unused_s;
  logic [CYC_W-1:0] cycle_cnt_r, br_cnt_r, jump_cnt_r;

  // Write-event qualification, trigger match and the entry to push.
  always_comb begin
    we_s          = wb_en && (waddr != {ADDR_W{1'b0}});
    trig_s        = (state_r == ARMED) && we_s && (waddr == trig_addr);
    push_s        = ((state_r == CAPTURE) && we_s) || trig_s;
    entry_s       = {$bits(trace_entry_t){1'b0}};
    entry_s.waddr = TR_ADDR_MAX'(waddr);
    entry_s.wdata = TR_DATA_MAX'(wdata);
    entry_s.cycle = TR_CYC_MAX'(cycle_cnt_r);
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WRAP  (WRAP_MODE != 0)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (clear),
    .push       (push_s),
    .push_entry (entry_s),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .head       (head_s),
    .count      (count),
    .full_hit   (full_hit_s)
  );

  // Capture FSM next state; clear wins over arm and trigger.
  always_comb begin
    state_next_s = state_r;
    if (clear) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_next_s = arm ? ARMED : IDLE;
        ARMED:   state_next_s = trig_s ? CAPTURE : ARMED;
        CAPTURE: state_next_s = (full_hit_s && (WRAP_MODE == 0)) ? DONE : CAPTURE;
        DONE:    state_next_s = DONE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Cycle stamp, saturating event counters and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cycle_cnt_r <= {CYC_W{1'b0}};
      br_cnt_r    <= {CYC_W{1'b0}};
      jump_cnt_r  <= {CYC_W{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      if (state_r != IDLE) begin
        cycle_cnt_r <= cycle_cnt_r + CYC_W'(1);
      end
      if ((state_r == CAPTURE) && br_taken && (br_cnt_r != {CYC_W{1'b1}})) begin
        br_cnt_r <= br_cnt_r + CYC_W'(1);
      end
      if ((state_r == CAPTURE) && jump && (jump_cnt_r != {CYC_W{1'b1}})) begin
        jump_cnt_r <= jump_cnt_r + CYC_W'(1);
      end
      if (full_hit_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign head_unused_s = ^head_s;
  assign rd_waddr      = head_s.waddr[ADDR_W-1:0];
  assign rd_wdata      = head_s.wdata[DATA_W-1:0];
  assign rd_cycle      = head_s.cycle[CYC_W-1:0];
  assign overflow      = overflow_r;
  assign state         = state_r;
  assign cycle_cnt     = cycle_cnt_r;
  assign br_cnt        = br_cnt_r;
  assign jump_cnt      = jump_cnt_r;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: a stop-mode and a wrap-mode instance (DEPTH=4,
// CYC_W=4) driven in lockstep and compared every cycle to a queue-based model.
module tb_wb_trace_buffer;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  c;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, wb_en, br_taken, jump, arm, clear, rd_ready;
  logic [4:0]  waddr, trig_addr;
  logic [31:0] wdata;

  logic        rd_valid_w [2];
  logic [4:0]  rd_waddr_w [2];
  logic [31:0] rd_wdata_w [2];
  logic [3:0]  rd_cycle_w [2];
  logic [2:0]  count_w    [2];
  logic        ovf_w      [2];
  logic [1:0]  state_w    [2];
  logic [3:0]  cyc_w      [2];
  logic [3:0]  br_w       [2];
  logic [3:0]  jmp_w      [2];

  int n_tests = 0;
  int n_fail  = 0;

  ent_t mq [2][$];
  int   mst [2], mcyc [2], mbr [2], mjmp [2];
  bit   movf [2];

  always #5 clk = ~clk;

  wb_trace_buffer #(.DATA_W(32), .ADDR_W(5), .DEPTH(4), .CYC_W(4), .WRAP_MODE(0)) u_stop (
    .clk(clk), .rst(rst), .wb_en(wb_en), .waddr(waddr), .wdata(wdata),
    .br_taken(br_taken), .jump(jump), .arm(arm), .clear(clear), .trig_addr(trig_addr),
    .rd_valid(rd_valid_w[0]), .rd_ready(rd_ready), .rd_waddr(rd_waddr_w[0]),
    .rd_wdata(rd_wdata_w[0]), .rd_cycle(rd_cycle_w[0]), .count(count_w[0]),
    .overflow(ovf_w[0]), .state(state_w[0]), .cycle_cnt(cyc_w[0]),
    .br_cnt(br_w[0]), .jump_cnt(jmp_w[0])
  );

  wb_trace_buffer #(.DATA_W(32), .ADDR_W(5), .DEPTH(4), .CYC_W(4), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .rst(rst), .wb_en(wb_en), .waddr(waddr), .wdata(wdata),
    .br_taken(br_taken), .jump(jump), .arm(arm), .clear(clear), .trig_addr(trig_addr),
    .rd_valid(rd_valid_w[1]), .rd_ready(rd_ready), .rd_waddr(rd_waddr_w[1]),
    .rd_wdata(rd_wdata_w[1]), .rd_cycle(rd_cycle_w[1]), .count(count_w[1]),
    .overflow(ovf_w[1]), .state(state_w[1]), .cycle_cnt(cyc_w[1]),
    .br_cnt(br_w[1]), .jump_cnt(jmp_w[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference model for instance i (1 = overwrite mode).
  task automatic model_step(input int i);
    bit   we, pop, push, wrap;
    ent_t e;
    wrap = (i == 1);
    if (rst || clear) begin
      mq[i].delete();
      mst[i] = 0; movf[i] = 1'b0; mcyc[i] = 0; mbr[i] = 0; mjmp[i] = 0;
      return;
    end
    we   = wb_en && (waddr != 5'd0);
    pop  = (mq[i].size() != 0) && rd_ready;
    push = (mst[i] == 2 && we) || (mst[i] == 1 && we && waddr == trig_addr);
    e    = '{a: waddr, d: wdata, c: 4'(mcyc[i])};
    if (mst[i] == 2) begin
      if (br_taken && mbr[i] < 15) mbr[i]++;
      if (jump && mjmp[i] < 15) mjmp[i]++;
    end
    if (mst[i] != 0) mcyc[i] = (mcyc[i] + 1) % 16;
    if (mst[i] == 0 && arm) mst[i] = 1;
    else if (mst[i] == 1 && push) mst[i] = 2;
    if (pop) void'(mq[i].pop_front());
    if (push) begin
      if (mq[i].size() == 4) begin
        movf[i] = 1'b1;
        if (wrap) begin
          void'(mq[i].pop_front());
          mq[i].push_back(e);
        end else begin
          mst[i] = 3;
        end
      end else begin
        mq[i].push_back(e);
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      ent_t h;
      h = (mq[i].size() != 0) ? mq[i][0] : ent_t'(41'd0);
      check($sformatf("u%0d.rd_valid", i), rd_valid_w[i], mq[i].size() != 0);
      check($sformatf("u%0d.rd_waddr", i), rd_waddr_w[i], h.a);
      check($sformatf("u%0d.rd_wdata", i), rd_wdata_w[i], h.d);
      check($sformatf("u%0d.rd_cycle", i), rd_cycle_w[i], h.c);
      check($sformatf("u%0d.count", i), count_w[i], mq[i].size());
      check($sformatf("u%0d.overflow", i), ovf_w[i], movf[i]);
      check($sformatf("u%0d.state", i), state_w[i], mst[i]);
      check($sformatf("u%0d.cycle_cnt", i), cyc_w[i], mcyc[i]);
      check($sformatf("u%0d.br_cnt", i), br_w[i], mbr[i]);
      check($sformatf("u%0d.jump_cnt", i), jmp_w[i], mjmp[i]);
    end
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic quiet();
    rst = 1'b0; wb_en = 1'b0; waddr = 5'd0; wdata = 32'd0; br_taken = 1'b0;
    jump = 1'b0; arm = 1'b0; clear = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; waddr = a; wdata = d;
    step();
    wb_en = 1'b0; waddr = 5'd0; wdata = 32'd0;
  endtask

  task automatic restart(input logic [4:0] t);
    clear = 1'b1; step(); clear = 1'b0;
    trig_addr = t;
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  initial begin
    quiet();
    trig_addr = 5'd0;
    rst = 1'b1; step(); step(); rst = 1'b0;
    step();

    // Trigger: x5 is not captured, x8 starts the capture.
    restart(5'd8);
    wr(5'd5, 32'h11);
    wr(5'd8, 32'hAA);
    for (int i = 0; i < 2; i++) begin
      check("trig.state", state_w[i], 2'd2);
      check("trig.head_addr", rd_waddr_w[i], 5'd8);
      check("trig.head_data", rd_wdata_w[i], 32'hAA);
      check("trig.count", count_w[i], 3'd1);
    end

    // Full behaviour: stop drops x5 and halts, wrap keeps the newest four.
    restart(5'd1);
    for (int k = 1; k <= 6; k++) wr(5'(k), 32'h100 + 32'(k));
    check("stop.state", state_w[0], 2'd3);
    check("stop.ovf", ovf_w[0], 1'b1);
    check("stop.count", count_w[0], 3'd4);
    check("wrap.state", state_w[1], 2'd2);
    check("wrap.ovf", ovf_w[1], 1'b1);
    check("wrap.count", count_w[1], 3'd4);
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("stop.order", rd_waddr_w[0], 5'(1 + k));
      check("wrap.order", rd_waddr_w[1], 5'(3 + k));
      step();
    end
    rd_ready = 1'b0;
    check("drain.valid", rd_valid_w[1], 1'b0);

    // Push and pop together at full.
    restart(5'd1);
    for (int k = 1; k <= 4; k++) wr(5'(k), 32'h200 + 32'(k));
    rd_ready = 1'b1;
    wr(5'd9, 32'h999);
    rd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("pp.count", count_w[i], 3'd4);
      check("pp.ovf", ovf_w[i], 1'b0);
      check("pp.head", rd_waddr_w[i], 5'd2);
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    rd_ready = 1'b0;

    // x0 never captured; branch/jump counters then saturate.
    restart(5'd1);
    wr(5'd1, 32'h1);
    wr(5'd0, 32'hFF);
    br_taken = 1'b1; jump = 1'b1;
    for (int k = 0; k < 3; k++) step();
    for (int i = 0; i < 2; i++) begin
      check("x0.count", count_w[i], 3'd1);
      check("ev.br", br_w[i], 4'd3);
      check("ev.jump", jmp_w[i], 4'd3);
    end
    for (int k = 0; k < 20; k++) step();
    br_taken = 1'b0; jump = 1'b0;
    check("sat.br", br_w[0], 4'd15);

    // Reset mid-capture with pending entries.
    restart(5'd2);
    wr(5'd2, 32'h2); wr(5'd3, 32'h3); wr(5'd4, 32'h4);
    check("pre_rst.count", count_w[0], 3'd3);
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst.count", count_w[i], 3'd0);
      check("rst.valid", rd_valid_w[i], 1'b0);
      check("rst.state", state_w[i], 2'd0);
      check("rst.cycle", cyc_w[i], 4'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 499) == 0);
      clear    = ($urandom_range(0, 59) == 0);
      arm      = ($urandom_range(0, 7) == 0);
      wb_en    = ($urandom_range(0, 9) < 6);
      waddr    = 5'($urandom_range(0, 7));
      wdata    = $urandom;
      br_taken = $urandom_range(0, 1) == 1;
      jump     = $urandom_range(0, 1) == 1;
      rd_ready = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 29) == 0) trig_addr = 5'($urandom_range(0, 7));
      step();
    end
    quiet();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning writeback data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning trace entries (power of two, >=2).
REQ-004 SHALL have parameter CYC_W, default 16, meaning cycle stamp and counter width.
REQ-005 SHALL have parameter WRAP_MODE, default 0: 0 = stop when full, 1 = overwrite oldest.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports wb_en (in, 1), waddr (in, ADDR_W) and wdata (in, DATA_W): the register-file write event.
REQ-009 SHALL have ports br_taken (in, 1) and jump (in, 1): per-cycle control-flow events.
REQ-010 SHALL have ports arm (in, 1), clear (in, 1) and trig_addr (in, ADDR_W): capture control.
REQ-011 SHALL have ports rd_valid (out, 1) and rd_ready (in, 1): the readout handshake.
REQ-012 SHALL have ports rd_waddr (out, ADDR_W), rd_wdata (out, DATA_W) and rd_cycle (out, CYC_W): the head entry.
REQ-013 SHALL have ports count (out, $clog2(DEPTH)+1), overflow (out, 1), state (out, 2), cycle_cnt (out, CYC_W), br_cnt (out, CYC_W) and jump_cnt (out, CYC_W).

Function
REQ-014 SHALL define a write event as wb_en=1 and waddr!=0.
- Writes to x0 are never captured and never trigger.
REQ-015 SHALL implement FSM states IDLE=0, ARMED=1, CAPTURE=2 and DONE=3, visible on state.
REQ-016 SHALL transition IDLE->ARMED on arm=1; arm is ignored in every other state.
REQ-017 SHALL transition ARMED->CAPTURE on a write event with waddr==trig_addr.
- The triggering write is captured as the first entry.
REQ-018 SHALL, in CAPTURE, push every write event as {waddr, wdata, cycle_cnt sampled that cycle}.
REQ-019 SHALL, when WRAP_MODE=0 and count==DEPTH with no pop, drop a push, set overflow, and enter DONE.
- Reaching full without a drop stays in CAPTURE.
REQ-020 SHALL, when WRAP_MODE=1 and count==DEPTH with no pop, overwrite the oldest entry, keep count=DEPTH, and set overflow.
- Never enters DONE in this mode.
REQ-021 SHALL accept both operations when a push and a pop occur in the same cycle at full; count is unchanged and overflow is not set.
REQ-022 SHALL drive rd_valid=(count!=0) and pop the head when rd_valid&&rd_ready.
- Outputs are registered: a pushed entry is visible with latency 1 cycle.
- On an empty buffer a same-cycle push is not poppable.
REQ-023 SHALL keep readout working in every state, including IDLE and DONE.
REQ-024 SHALL make overflow sticky until clear or rst.
REQ-025 SHALL increment cycle_cnt every cycle while state!=IDLE, wrapping modulo 2^CYC_W.
REQ-026 SHALL increment br_cnt on br_taken and jump_cnt on jump, only in CAPTURE, saturating at 2^CYC_W-1.
- br_taken and jump in the same cycle increment both counters.
REQ-027 SHALL, on clear=1, return to IDLE and zero the FIFO, count, overflow and all counters next cycle.
- clear overrides arm, push and pop in that cycle.
- Buffer contents become don't-care.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, set state=IDLE and count, overflow, cycle_cnt, br_cnt, jump_cnt, rd_valid, rd_waddr, rd_wdata and rd_cycle all to 0.
REQ-029 SHALL give rst priority over clear and all other inputs, including a reset mid-capture with pending entries; those entries are discarded.

Structure
REQ-030 SHALL place the state enum (trace_state_t) and the trace entry struct (trace_entry_t) in shared package trace_pkg.
REQ-031 SHALL implement storage as one sub-module, trace_fifo, providing push/pop/overwrite/count.
- FSM, trigger and counters live in wb_trace_buffer.

Verification
REQ-032 SHALL cover trigger: arm; write x5=0x11 then x8=0xAA with trig_addr=8 -> first entry {8,0xAA}, state=CAPTURE; x5 not captured.
REQ-033 SHALL cover stop-mode full: DEPTH=4, WRAP_MODE=0, 5 writes x1..x5 with no reads -> entries x1..x4, overflow=1, state=DONE.
REQ-034 SHALL cover wrap mode: DEPTH=4, WRAP_MODE=1, writes x1..x6 -> read order x3,x4,x5,x6; count=4 before reads; overflow=1.
REQ-035 SHALL cover simultaneous push/pop at full: DEPTH=4 full, rd_ready=1 plus a write to x9 -> count stays 4, overflow=0, x9 becomes the tail.
REQ-036 SHALL cover x0 and counters: write x0=0xFF and 3 cycles of br_taken=jump=1 in CAPTURE -> no entry; br_cnt=3, jump_cnt=3.
REQ-037 SHALL cover reset mid-capture: rst with count=3 -> next cycle count=0, rd_valid=0, state=IDLE, cycle_cnt=0.
